sum_window_acc: RTL
===================

Name: sum_window_acc

Overview:
- Downstream consumer of the registered 8-bit adder sum stream.
- Accepts one sum per valid/ready handshake and accumulates a fixed window of WINDOW samples.
- At window end, emits the window total, the window average and a saturation flag through a second valid/ready handshake.
- Feeds the statistics/counter logic that follows the adder stage.

Parameters:
- DATA_W, 8, width of each incoming sum sample.
- WINDOW, 4, samples per window; power of two, legal range 2..256.
- ACC_W, 16, accumulator and total width; must be >= DATA_W.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a valid sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  sample (adder sum).
- flush  input  1  synchronous discard of the partial window.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  saturated window total.
- out_avg  output  DATA_W  window average, truncating.
- out_sat  output  1  accumulator saturated during this window.
- sample_cnt  output  8  samples accepted in the current partial window.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACC, acc=0, sample_cnt=0, sat=0.
  - out_valid=0, out_sum=0, out_avg=0, out_sat=0.
  - in_ready=1 from the first clock after release.
- States: ACC (collecting), OUT (holding result). in_ready = (state==ACC); a registered/decoded state bit, no combinational path from out_ready.
- Accept = in_valid & in_ready.
- Accumulate rule:
  - acc_next = acc + zero-extended in_data.
  - If the true sum exceeds 2^ACC_W-1, acc_next = all-ones and the sticky sat bit is set for the window.
  - There is no wrap-around.
- Non-final accept (sample_cnt < WINDOW-1): acc <= acc_next, sample_cnt++.
- Final accept (sample_cnt == WINDOW-1), on that edge:
  - out_sum <= acc_next.
  - out_avg <= acc_next >> log2(WINDOW), truncated to the low DATA_W bits; saturates to all-ones if any higher bit is set.
  - out_sat <= sat | overflow-this-sample.
  - acc, sample_cnt, sat cleared; state <= OUT.
  - out_valid rises in the cycle after the final accept (latency 1).
- OUT state:
  - out_valid=1; out_sum/out_avg/out_sat held stable until out_ready=1.
  - On out_valid & out_ready: state <= ACC, out_valid <= 0, in_ready=1 next cycle.
  - Result fields keep their last value after the handshake (not cleared).
  - Minimum one bubble between windows.
- flush:
  - In ACC: acc, sample_cnt, sat cleared next edge.
  - flush + simultaneous accept: flush wins, sample dropped, no window completes.
  - In OUT: ignored; the pending result is still delivered.
- in_valid while in_ready=0: no effect; upstream holds data.
- out_ready while out_valid=0: no effect.
- Reset mid-window or mid-OUT: partial window and pending result are lost; outputs return to reset values immediately (async).
- WINDOW=256: sample_cnt reaches 255, then wraps to 0 at window end.

Test Plan:
- Reset release, WINDOW=4: feed 10,20,30,40 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept; out_sum=100, out_avg=25, out_sat=0; in_ready low exactly 1 cycle.
- Backpressure: same window with out_ready=0 for 5 cycles -> out_valid and fields stable for 5 cycles, in_ready=0 throughout; new window starts only after the handshake.
- Saturation, ACC_W=9: feed 255 x4 -> out_sum=511, out_sat=1, out_avg=127; next window 1,1,1,1 -> out_sum=4, out_sat=0 (sat cleared per window).
- Flush: feed 50,60, then flush coincident with sample 70, then 1,2,3,4 -> single result out_sum=10, out_avg=2, sample_cnt=0 after flush.
- Async reset asserted during OUT with out_valid=1 -> out_valid=0 and out_sum=0 without a clock edge; after release, 5,5,5,5 -> out_sum=20.
- Gapped in_valid (one sample every 3 cycles): 7,8,9,10 -> out_sum=34, out_avg=8; sample_cnt steps 1,2,3, then 0.

Source files
------------

// File: rtl/sum_window_acc.sv
// Windowed accumulator for the adder sum stream: collects WINDOW samples,
// then presents a saturated total, truncating average and saturation flag.
module sum_window_acc #(
    parameter int DATA_W = 8,
    parameter int WINDOW = 4,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_avg,
    output logic              out_sat,
    output logic [7:0]        sample_cnt
);

    localparam int SHIFT = $clog2(WINDOW);
    localparam logic [7:0] CNT_LAST = 8'(WINDOW - 1);
    // Largest average representable in DATA_W bits, held at the widened width.
    localparam logic [ACC_W:0] AVG_MAX =
        ({{ACC_W{1'b0}}, 1'b1} << DATA_W) - {{ACC_W{1'b0}}, 1'b1};

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [DATA_W-1:0]  out_avg_q, out_avg_d;
    logic               out_sat_q, out_sat_d;

    logic [ACC_W:0]     sum_full_s;
    logic               ovf_s;
    logic [ACC_W-1:0]   acc_next_s;
    logic [ACC_W:0]     avg_wide_s;
    logic [DATA_W-1:0]  avg_s;
    logic               accept_s;
    logic               last_s;

    // Saturating add of the incoming sample and average of the resulting total.
    always_comb begin
        sum_full_s = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
        ovf_s      = sum_full_s[ACC_W];
        if (ovf_s) begin
            acc_next_s = {ACC_W{1'b1}};
        end else begin
            acc_next_s = sum_full_s[ACC_W-1:0];
        end
        avg_wide_s = {1'b0, acc_next_s} >> SHIFT;
        if (avg_wide_s > AVG_MAX) begin
            avg_s = {DATA_W{1'b1}};
        end else begin
            avg_s = avg_wide_s[DATA_W-1:0];
        end
        accept_s = in_valid && (state_q == ST_ACC);
        last_s   = (cnt_q == CNT_LAST);
    end

    // Next-state logic: flush beats a coincident sample; OUT ignores flush.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_avg_d   = out_avg_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ST_ACC: begin
                if (flush) begin
                    acc_d = {ACC_W{1'b0}};
                    cnt_d = 8'd0;
                    sat_d = 1'b0;
                end else if (accept_s && last_s) begin
                    out_sum_d   = acc_next_s;
                    out_avg_d   = avg_s;
                    out_sat_d   = sat_q | ovf_s;
                    out_valid_d = 1'b1;
                    acc_d       = {ACC_W{1'b0}};
                    cnt_d       = 8'd0;
                    sat_d       = 1'b0;
                    state_d     = ST_OUT;
                end else if (accept_s) begin
                    acc_d = acc_next_s;
                    cnt_d = cnt_q + 8'd1;
                    sat_d = sat_q | ovf_s;
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_ACC;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_ACC;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= 8'd0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= {ACC_W{1'b0}};
            out_avg_q   <= {DATA_W{1'b0}};
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_avg_q   <= out_avg_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready   = (state_q == ST_ACC);
    assign out_valid  = out_valid_q;
    assign out_sum    = out_sum_q;
    assign out_avg    = out_avg_q;
    assign out_sat    = out_sat_q;
    assign sample_cnt = cnt_q;

endmodule
